dma_addr_sequencer: RTL and testbench

- Parametrised successor to the combinational DMA address generator.
- Accepts one tile-transfer request and sequences it into a series of DMA descriptors (byte address, byte length), one outstanding at a time.
- Handles PW/DW filters, ifmap, bias and opsum, including clamping of the last partial spatial tile.
- Sits between tile_scheduler (request side) and the DMA engine (descriptor/done side).

---
 rtl/dma_addr_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_dma_addr_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dma_addr_sequencer.sv
`timescale 1ns/1ps
// Turns one tile-transfer request into a sequence of DMA descriptors (byte address, byte length).
// Only one descriptor is outstanding at a time; later addresses come from a running add of the stride.
module dma_addr_sequencer #(
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 16,
    parameter int PLANE_W     = 20,
    parameter int CH_W        = 10,
    parameter int OPSUM_BYTES = 2,
    parameter int BIAS_BYTES  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [1:0]         layer_type_i,
    input  logic [1:0]         data_type_i,
    input  logic [ADDR_W-1:0]  base_addr_i,
    input  logic [PLANE_W-1:0] plane_size_i,
    input  logic [PLANE_W-1:0] tile_n_i,
    input  logic [PLANE_W-1:0] tile_idx_i,
    input  logic [CH_W-1:0]    ch_base_i,
    input  logic [CH_W-1:0]    ch_cnt_i,
    input  logic [CH_W-1:0]    in_D_i,
    input  logic [CH_W-1:0]    d_base_i,
    input  logic [CH_W-1:0]    tile_D_i,
    output logic               desc_valid_o,
    input  logic               desc_ready_i,
    output logic [ADDR_W-1:0]  desc_addr_o,
    output logic [LEN_W-1:0]   desc_len_o,
    input  logic               dma_done_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               error_o,
    output logic [CH_W-1:0]    desc_idx_o,
    output logic [2:0]         dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALC  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam int PW2 = 2 * PLANE_W;
    localparam logic [1:0] DT_IFMAP = 2'd1;
    localparam logic [1:0] DT_BIAS  = 2'd2;
    localparam logic [1:0] DT_OPSUM = 2'd3;
    localparam logic [1:0] LT_DW    = 2'd1;

    state_t             state;
    logic [1:0]         r_layer, r_dtype;
    logic [ADDR_W-1:0]  r_base, stride;
    logic [PLANE_W-1:0] r_plane, r_tile_n, r_tile_idx;
    logic [CH_W-1:0]    r_ch_base, r_ch_cnt, r_in_d, r_d_base, r_tile_d, n_desc;

    logic [PW2-1:0]     off_w;
    logic [PLANE_W-1:0] remain, elems;
    logic [ADDR_W-1:0]  e_sz, len_w, c_addr, c_stride;
    logic [LEN_W-1:0]   c_len;
    logic [CH_W-1:0]    c_n;
    logic               c_err;

    assign dbg_state_o = state;

    // Offset product is kept double width so an out-of-range tile cannot wrap back into the plane.
    always_comb begin
        off_w    = PW2'(r_tile_idx) * PW2'(r_tile_n);
        remain   = r_plane - off_w[PLANE_W-1:0];
        elems    = (r_tile_n < remain) ? r_tile_n : remain;
        e_sz     = (r_dtype == DT_OPSUM) ? ADDR_W'(OPSUM_BYTES) : ADDR_W'(1);
        c_err    = 1'b0;
        c_addr   = r_base;
        c_stride = '0;
        len_w    = '0;
        c_n      = r_ch_cnt;
        case (r_dtype)
            DT_IFMAP, DT_OPSUM: begin
                c_err    = (off_w >= PW2'(r_plane));
                c_addr   = r_base + (ADDR_W'(r_ch_base) * ADDR_W'(r_plane) + ADDR_W'(off_w)) * e_sz;
                c_stride = ADDR_W'(r_plane) * e_sz;
                len_w    = ADDR_W'(elems) * e_sz;
            end
            DT_BIAS: begin
                c_addr = r_base + ADDR_W'(r_ch_base) * ADDR_W'(BIAS_BYTES);
                len_w  = ADDR_W'(r_ch_cnt) * ADDR_W'(BIAS_BYTES);
                c_n    = CH_W'(1);
            end
            default: begin
                if (r_layer == LT_DW) begin
                    c_addr = r_base + ADDR_W'(r_ch_base) * ADDR_W'(9);
                    len_w  = ADDR_W'(r_ch_cnt) * ADDR_W'(9);
                    c_n    = CH_W'(1);
                end else begin
                    c_addr   = r_base + ADDR_W'(r_ch_base) * ADDR_W'(r_in_d) + ADDR_W'(r_d_base);
                    c_stride = ADDR_W'(r_in_d);
                    len_w    = ADDR_W'(r_tile_d);
                end
            end
        endcase
        c_len = LEN_W'(len_w);
    end

    // Handshake: desc_valid_o stays high with addr/len/idx frozen until a cycle where desc_ready_i
    // is also high; that cycle transfers the descriptor. dma_done_i counts only while in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            desc_valid_o <= 1'b0;
            desc_addr_o  <= '0;
            desc_len_o   <= '0;
            desc_idx_o   <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
            stride       <= '0;
            n_desc       <= '0;
            r_layer      <= '0;
            r_dtype      <= '0;
            r_base       <= '0;
            r_plane      <= '0;
            r_tile_n     <= '0;
            r_tile_idx   <= '0;
            r_ch_base    <= '0;
            r_ch_cnt     <= '0;
            r_in_d       <= '0;
            r_d_base     <= '0;
            r_tile_d     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        r_layer    <= layer_type_i;
                        r_dtype    <= data_type_i;
                        r_base     <= base_addr_i;
                        r_plane    <= plane_size_i;
                        r_tile_n   <= tile_n_i;
                        r_tile_idx <= tile_idx_i;
                        r_ch_base  <= ch_base_i;
                        r_ch_cnt   <= ch_cnt_i;
                        r_in_d     <= in_D_i;
                        r_d_base   <= d_base_i;
                        r_tile_d   <= tile_D_i;
                        desc_idx_o <= '0;
                        busy_o     <= 1'b1;
                        state      <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (c_err) begin
                        error_o <= 1'b1;
                        state   <= S_ERR;
                    end else if (c_n == '0) begin
                        done_o <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        desc_addr_o  <= c_addr;
                        desc_len_o   <= c_len;
                        stride       <= c_stride;
                        n_desc       <= c_n;
                        desc_valid_o <= 1'b1;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (desc_ready_i) begin
                        desc_valid_o <= 1'b0;
                        state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dma_done_i) begin
                        if (desc_idx_o == n_desc - CH_W'(1)) begin
                            done_o <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            desc_idx_o   <= desc_idx_o + CH_W'(1);
                            desc_addr_o  <= desc_addr_o + stride;
                            desc_valid_o <= 1'b1;
                            state        <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                S_ERR: begin
                    error_o <= 1'b0;
                    busy_o  <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_addr_sequencer.sv
`timescale 1ns/1ps
// Directed bench for dma_addr_sequencer: hand-computed descriptor lists checked through one scoreboard queue.
module tb_dma_addr_sequencer;

    localparam int ADDR_W  = 32;
    localparam int LEN_W   = 16;
    localparam int PLANE_W = 20;
    localparam int CH_W    = 10;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start_i = 1'b0;
    logic [1:0]         layer_type_i = '0;
    logic [1:0]         data_type_i = '0;
    logic [ADDR_W-1:0]  base_addr_i = '0;
    logic [PLANE_W-1:0] plane_size_i = '0;
    logic [PLANE_W-1:0] tile_n_i = '0;
    logic [PLANE_W-1:0] tile_idx_i = '0;
    logic [CH_W-1:0]    ch_base_i = '0;
    logic [CH_W-1:0]    ch_cnt_i = '0;
    logic [CH_W-1:0]    in_D_i = '0;
    logic [CH_W-1:0]    d_base_i = '0;
    logic [CH_W-1:0]    tile_D_i = '0;
    logic               desc_valid_o;
    logic               desc_ready_i = 1'b1;
    logic [ADDR_W-1:0]  desc_addr_o;
    logic [LEN_W-1:0]   desc_len_o;
    logic               dma_done_i = 1'b0;
    logic               busy_o, done_o, error_o;
    logic [CH_W-1:0]    desc_idx_o;
    logic [2:0]         dbg_state_o;

    logic [ADDR_W+LEN_W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    dma_addr_sequencer #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .PLANE_W(PLANE_W), .CH_W(CH_W),
        .OPSUM_BYTES(4), .BIAS_BYTES(2)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .layer_type_i(layer_type_i), .data_type_i(data_type_i),
        .base_addr_i(base_addr_i), .plane_size_i(plane_size_i),
        .tile_n_i(tile_n_i), .tile_idx_i(tile_idx_i),
        .ch_base_i(ch_base_i), .ch_cnt_i(ch_cnt_i),
        .in_D_i(in_D_i), .d_base_i(d_base_i), .tile_D_i(tile_D_i),
        .desc_valid_o(desc_valid_o), .desc_ready_i(desc_ready_i),
        .desc_addr_o(desc_addr_o), .desc_len_o(desc_len_o),
        .dma_done_i(dma_done_i), .busy_o(busy_o), .done_o(done_o),
        .error_o(error_o), .desc_idx_o(desc_idx_o), .dbg_state_o(dbg_state_o)
    );

    // Clock and reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic expect_desc(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        exp_q.push_back({a, l});
    endtask

    task automatic start_req(input logic [1:0] dt, input logic [1:0] lt, input logic [ADDR_W-1:0] base,
                             input int plane, input int tn, input int tidx, input int chb,
                             input int chc, input int ind, input int dbase, input int tiled);
        data_type_i  = dt;
        layer_type_i = lt;
        base_addr_i  = base;
        plane_size_i = PLANE_W'(plane);
        tile_n_i     = PLANE_W'(tn);
        tile_idx_i   = PLANE_W'(tidx);
        ch_base_i    = CH_W'(chb);
        ch_cnt_i     = CH_W'(chc);
        in_D_i       = CH_W'(ind);
        d_base_i     = CH_W'(dbase);
        tile_D_i     = CH_W'(tiled);
        start_i      = 1'b1;
        @(negedge clk);
        start_i      = 1'b0;
    endtask

    // DMA-side driver: accepts descriptors and answers with dma_done two cycles after each accept.
    task automatic serve(input int hold, input int count, input int idx0, input bit finish_last);
        logic [ADDR_W+LEN_W-1:0] exp;
        int waited;
        for (int i = 0; i < count; i++) begin
            waited = 0;
            while (!desc_valid_o && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            check("valid_seen", 64'(desc_valid_o), 64'd1);
            if (!desc_valid_o) return;
            if (i > 0) check("next_valid_latency", 64'(waited), 64'd0);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            check("desc_addr_len", 64'({desc_addr_o, desc_len_o}), 64'(exp));
            check("desc_idx", 64'(desc_idx_o), 64'(idx0 + i));
            if (hold > 0) begin
                for (int k = 0; k < hold; k++) begin
                    dma_done_i = (k == 2);
                    @(negedge clk);
                    check("hold_stable", 64'({desc_valid_o, desc_addr_o, desc_len_o, desc_idx_o}),
                          64'({1'b1, exp, CH_W'(idx0 + i)}));
                end
                dma_done_i   = 1'b0;
                desc_ready_i = 1'b1;
                @(negedge clk);
                desc_ready_i = 1'b0;
            end else begin
                @(negedge clk);
            end
            check("valid_dropped", 64'(desc_valid_o), 64'd0);
            if (i == count - 1 && !finish_last) return;
            @(negedge clk);
            dma_done_i = 1'b1;
            @(negedge clk);
            dma_done_i = 1'b0;
        end
        if (finish_last) begin
            check("done_pulse", 64'({done_o, desc_valid_o}), 64'b10);
            @(negedge clk);
            check("back_idle", 64'({busy_o, done_o}), 64'd0);
        end
    endtask

    initial begin
        do_reset();
        check("reset_outputs", 64'({desc_valid_o, desc_addr_o, desc_len_o, busy_o, done_o, error_o, desc_idx_o}), 64'd0);
        check("reset_state", 64'(dbg_state_o), 64'd0);

        // ifmap PW: off=192, len=min(64,4)=4, addr0=0x1000+(2*196+192)
        expect_desc(32'h1248, 16'd4);
        expect_desc(32'h130C, 16'd4);
        expect_desc(32'h13D0, 16'd4);
        start_req(2'd1, 2'd0, 32'h1000, 196, 64, 3, 2, 3, 0, 0, 0);
        check("calc_no_valid", 64'({desc_valid_o, busy_o}), 64'b01);
        @(negedge clk);
        check("first_valid_t2", 64'(desc_valid_o), 64'd1);
        serve(0, 3, 0, 1);

        // opsum with 4-byte elements
        expect_desc(32'h80C4, 16'd128);
        expect_desc(32'h8188, 16'd128);
        start_req(2'd3, 2'd0, 32'h8000, 49, 32, 0, 1, 2, 0, 0, 0);
        serve(0, 2, 0, 1);

        // PW filter, with a second start pulsed during CALC that must be ignored
        expect_desc(32'h2120, 16'd32);
        expect_desc(32'h2160, 16'd32);
        start_req(2'd0, 2'd0, 32'h2000, 0, 0, 0, 4, 2, 64, 32, 32);
        start_i     = 1'b1;
        base_addr_i = 32'hDEAD0000;
        data_type_i = 2'd2;
        @(negedge clk);
        start_i = 1'b0;
        serve(0, 2, 0, 1);

        // DW filter and bias
        expect_desc(32'h3048, 16'd144);
        start_req(2'd0, 2'd1, 32'h3000, 0, 0, 0, 8, 16, 0, 0, 0);
        serve(0, 1, 0, 1);
        expect_desc(32'h4010, 16'd32);
        start_req(2'd2, 2'd0, 32'h4000, 0, 0, 0, 8, 16, 0, 0, 0);
        serve(0, 1, 0, 1);

        // Backpressure with spurious dma_done during ISSUE
        desc_ready_i = 1'b0;
        expect_desc(32'h2120, 16'd32);
        expect_desc(32'h2160, 16'd32);
        start_req(2'd0, 2'd0, 32'h2000, 0, 0, 0, 4, 2, 64, 32, 32);
        serve(5, 2, 0, 1);
        desc_ready_i = 1'b1;

        // Tile fully past the plane -> error, no descriptor
        start_req(2'd1, 2'd0, 32'h1000, 196, 64, 4, 2, 3, 0, 0, 0);
        @(negedge clk);
        check("err_pulse", 64'({error_o, desc_valid_o}), 64'b10);
        @(negedge clk);
        check("err_idle", 64'({error_o, busy_o, desc_valid_o}), 64'd0);

        // Zero channels -> done with no descriptors
        start_req(2'd1, 2'd0, 32'h1000, 196, 64, 0, 2, 0, 0, 0, 0);
        @(negedge clk);
        check("empty_done", 64'({done_o, desc_valid_o}), 64'b10);
        @(negedge clk);
        check("empty_idle", 64'({done_o, busy_o}), 64'd0);

        // Reset while waiting on the 2nd descriptor, then a late dma_done
        expect_desc(32'h1248, 16'd4);
        expect_desc(32'h130C, 16'd4);
        start_req(2'd1, 2'd0, 32'h1000, 196, 64, 3, 2, 3, 0, 0, 0);
        serve(0, 2, 0, 0);
        check("in_wait", 64'(dbg_state_o), 64'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_reset_outputs", 64'({desc_valid_o, desc_addr_o, desc_len_o, busy_o, done_o, error_o, desc_idx_o}), 64'd0);
        check("mid_reset_state", 64'(dbg_state_o), 64'd0);
        dma_done_i = 1'b1;
        @(negedge clk);
        dma_done_i = 1'b0;
        @(negedge clk);
        check("late_done_ignored", 64'({desc_valid_o, busy_o, done_o}), 64'd0);
        exp_q.delete();
        expect_desc(32'h1248, 16'd4);
        expect_desc(32'h130C, 16'd4);
        expect_desc(32'h13D0, 16'd4);
        start_req(2'd1, 2'd0, 32'h1000, 196, 64, 3, 2, 3, 0, 0, 0);
        serve(0, 3, 0, 1);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
